// File: rtl/mac_issue_sequencer.sv
// Layer MAC initiator: issues read strobes per neuron, accumulates signed products,
// and presents each neuron's saturated fixed-point result on a valid/ready port.
module mac_issue_sequencer #(
    parameter int DW    = 8,
    parameter int FRAC  = 4,
    parameter int N_IN  = 2,
    parameter int N_OUT = 2,
    parameter int ACC_W = 2*DW + $clog2(N_IN) + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             rd_en,
    output logic [$clog2(N_IN)-1:0]          in_addr,
    output logic [$clog2(N_IN*N_OUT)-1:0]    w_addr,
    input  logic [DW-1:0]                    in_data,
    input  logic [DW-1:0]                    w_data,
    output logic [DW-1:0]                    out_data,
    output logic [$clog2(N_OUT)-1:0]         out_idx,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy,
    output logic                             done
);

    localparam int IW = $clog2(N_IN);
    localparam int JW = $clog2(N_OUT);
    localparam int WW = $clog2(N_IN*N_OUT);

    localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W)'((1 << (DW-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [IW-1:0]            i_q, i_d;
    logic [JW-1:0]            j_q, j_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     rv_q, rv_d;
    logic                     done_q, done_d;

    logic signed [DW-1:0]     in_s;
    logic signed [DW-1:0]     w_s;
    logic signed [2*DW-1:0]   prod;
    logic [ACC_W-1:0]         prod_ext;
    logic signed [ACC_W-1:0]  acc_sh;
    logic [DW-1:0]            sat_data;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            rv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            rv_q    <= rv_d;
            done_q  <= done_d;
        end
    end

    // Full-width signed product, sign-extended into the accumulator untruncated.
    always_comb begin
        in_s     = in_data;
        w_s      = w_data;
        prod     = in_s * w_s;
        prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        acc_d   = acc_q;
        rv_d    = 1'b0;
        done_d  = 1'b0;
        if (rv_q) begin
            acc_d = acc_q + prod_ext;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    i_d     = '0;
                    j_d     = '0;
                    acc_d   = '0;
                end
            end
            S_ISSUE: begin
                rv_d = 1'b1;
                if (i_q == IW'(N_IN-1)) begin
                    state_d = S_DRAIN;
                    i_d     = '0;
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            S_DRAIN: begin
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    if (j_q == JW'(N_OUT-1)) begin
                        state_d = S_IDLE;
                        j_d     = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        j_d     = j_q + JW'(1);
                        i_d     = '0;
                        acc_d   = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Arithmetic shift floors toward -inf before clamping to the DW range.
    always_comb begin
        acc_sh = acc_q >>> FRAC;
        if (acc_sh > SAT_MAX) begin
            sat_data = SAT_MAX[DW-1:0];
        end else if (acc_sh < SAT_MIN) begin
            sat_data = SAT_MIN[DW-1:0];
        end else begin
            sat_data = acc_sh[DW-1:0];
        end
    end

    always_comb begin
        rd_en     = (state_q == S_ISSUE);
        in_addr   = '0;
        w_addr    = '0;
        out_valid = (state_q == S_OUT);
        out_data  = '0;
        out_idx   = '0;
        busy      = (state_q != S_IDLE);
        done      = done_q;
        if (state_q == S_ISSUE) begin
            in_addr = i_q;
            w_addr  = WW'(j_q) * WW'(N_IN) + WW'(i_q);
        end
        if (state_q == S_OUT) begin
            out_data = sat_data;
            out_idx  = j_q;
        end
    end

endmodule
